// File: rtl/mm6532_pkg.sv
`default_nettype none
// ============================================================================
// mm6532_pkg : shared encodings for the timer/interrupt register bank
// Rev 1.0
// ============================================================================
package mm6532_pkg;

  typedef enum logic [1:0] {
    C_TIM_0001T = 2'b00,
    C_TIM_0008T = 2'b01,
    C_TIM_0064T = 2'b10,
    C_TIM_1024T = 2'b11
  } tim_mode_e;

  localparam int A_FLAGSEL = 0;
  localparam int A_TIMER   = 2;
  localparam int A_IEN     = 3;
  localparam int A_WSEL    = 4;
  localparam int A_PPOL    = 0;
  localparam int A_PEN     = 1;

  localparam int PFLAG = 6;
  localparam int TFLAG = 7;

endpackage
`default_nettype wire

// File: rtl/edge_det.sv
`default_nettype none
// ============================================================================
// edge_det : PA7 synchronizer with a polarity-selectable edge detector
// Rev 1.0
// ============================================================================
module edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  input  logic pol_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [SYNC_STAGES:0]   fill_q;
  logic                   s_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are ignored until both the synchronizer and the history flop carry real samples.
  assign s_last = sync_q[SYNC_STAGES-1];
  assign edge_o = fill_q[SYNC_STAGES] & (pol_i ? (s_last & ~hist_q) : (~s_last & hist_q));

endmodule
`default_nettype wire

// File: rtl/timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// timer_irq_ctrl : interval-timer bus decode plus timer/PA7 interrupt flags
// Rev 1.0
// ============================================================================
module timer_irq_ctrl
  import mm6532_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       CS,
  input  logic       RW,
  input  logic [4:0] A,
  input  logic [7:0] DIN,
  input  logic       PA7,
  input  logic       TIM_UF,
  input  logic [7:0] TIM_OUT,
  output logic       TIM_WE,
  output logic [1:0] TIM_MODE,
  output logic [7:0] TIM_IN,
  output logic [7:0] DOUT,
  output logic       IRQ_N
);

  logic tim_wr, ctl_wr, tim_rd, flg_rd, pa7_edge;
  logic tflag_q, tflag_d, pflag_q, pflag_d;
  logic ten_q, ten_d, pen_q, pen_d, ppol_q, ppol_d;

  assign tim_wr = CS & ~RW &  A[A_WSEL] & A[A_TIMER];
  assign ctl_wr = CS & ~RW & ~A[A_WSEL] & A[A_TIMER];
  assign tim_rd = CS &  RW & A[A_TIMER] & ~A[A_FLAGSEL];
  assign flg_rd = CS &  RW & A[A_TIMER] &  A[A_FLAGSEL];

  assign TIM_WE   = tim_wr & ~RES;
  assign TIM_MODE = A[1:0];
  assign TIM_IN   = DIN;

  edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_det (
    .clk_i (CLK),
    .rst_i (RES),
    .d_i   (PA7),
    .pol_i (ppol_q),
    .edge_o(pa7_edge)
  );

  always_comb begin
    DOUT = 8'h00;
    if (tim_rd) begin
      DOUT = TIM_OUT;
    end else if (flg_rd) begin
      DOUT[TFLAG] = tflag_q;
      DOUT[PFLAG] = pflag_q;
    end
  end

  // Statement order encodes priority: underflow beats a read-clear, a write-clear beats underflow.
  always_comb begin
    ten_d   = ten_q;
    pen_d   = pen_q;
    ppol_d  = ppol_q;
    tflag_d = tflag_q;
    pflag_d = pflag_q;
    if (tim_wr | tim_rd) ten_d = A[A_IEN];
    if (ctl_wr) begin
      pen_d  = A[A_PEN];
      ppol_d = A[A_PPOL];
    end
    if (tim_rd)   tflag_d = 1'b0;
    if (TIM_UF)   tflag_d = 1'b1;
    if (tim_wr)   tflag_d = 1'b0;
    if (flg_rd)   pflag_d = 1'b0;
    if (pa7_edge) pflag_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      tflag_q <= 1'b0;
      pflag_q <= 1'b0;
      ten_q   <= 1'b0;
      pen_q   <= 1'b0;
      ppol_q  <= 1'b0;
    end else begin
      tflag_q <= tflag_d;
      pflag_q <= pflag_d;
      ten_q   <= ten_d;
      pen_q   <= pen_d;
      ppol_q  <= ppol_d;
    end
  end

  assign IRQ_N = ~((tflag_q & ten_q) | (pflag_q & pen_q));

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_timer_irq_ctrl : directed self-checking bench for timer_irq_ctrl
// Rev 1.0
// ============================================================================
module tb_timer_irq_ctrl;

  localparam int SYNC_STAGES = 2;

  logic       CLK = 1'b0;
  logic       RES, CS, RW, PA7, TIM_UF;
  logic [4:0] A;
  logic [7:0] DIN, TIM_OUT;
  logic       TIM_WE, IRQ_N;
  logic [1:0] TIM_MODE;
  logic [7:0] TIM_IN, DOUT;

  timer_irq_ctrl #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK(CLK), .RES(RES), .CS(CS), .RW(RW), .A(A), .DIN(DIN),
    .PA7(PA7), .TIM_UF(TIM_UF), .TIM_OUT(TIM_OUT),
    .TIM_WE(TIM_WE), .TIM_MODE(TIM_MODE), .TIM_IN(TIM_IN),
    .DOUT(DOUT), .IRQ_N(IRQ_N)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic sb_push(input string tag, input logic [7:0] v);
    sbq.push_back('{tag, v});
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus(input logic cs, input logic rw, input logic [4:0] a, input logic [7:0] d);
    CS = cs; RW = rw; A = a; DIN = d;
  endtask

  task automatic idle();
    bus(1'b0, 1'b1, 5'h00, 8'h00);
  endtask

  task automatic flag_read(input string tag, input logic [7:0] v);
    bus(1'b1, 1'b1, 5'h05, 8'h00);
    #1;
    sb_push(tag, v);
    chk(DOUT);
    tick();
    idle();
  endtask

  initial begin
    int n;
    TIM_OUT = 8'hA5;
    PA7 = 1'b0;
    RES = 1'b1;
    TIM_UF = 1'b1;
    bus(1'b1, 1'b0, 5'h1D, 8'hFF);
    #1;
    sb_push("we_forced_in_reset", 8'h00); chk(TIM_WE);
    tick();
    sb_push("irq_in_reset", 8'h01); chk(IRQ_N);
    tick();
    RES = 1'b0; TIM_UF = 1'b0; idle();
    repeat (4) tick();
    flag_read("flags_after_reset", 8'h00);

    // Timer write with enable, then underflow
    bus(1'b1, 1'b0, 5'h1D, 8'h05);
    #1;
    sb_push("tim_we", 8'h01);   chk(TIM_WE);
    sb_push("tim_mode", 8'h01); chk(TIM_MODE);
    sb_push("tim_in", 8'h05);   chk(TIM_IN);
    tick(); idle();
    sb_push("irq_ten_noflag", 8'h01); chk(IRQ_N);
    TIM_UF = 1'b1; tick(); TIM_UF = 1'b0;
    sb_push("irq_after_uf", 8'h00); chk(IRQ_N);
    flag_read("flag_read_tflag", 8'h80);
    sb_push("irq_after_flagrd", 8'h00); chk(IRQ_N);

    // Timer reads: underflow during read keeps TFLAG, plain read clears it
    bus(1'b1, 1'b1, 5'h0C, 8'h00); TIM_UF = 1'b1;
    #1;
    sb_push("tim_read_dout", 8'hA5); chk(DOUT);
    tick(); TIM_UF = 1'b0; idle();
    sb_push("irq_uf_read_setwins", 8'h00); chk(IRQ_N);
    bus(1'b1, 1'b1, 5'h04, 8'h00);
    #1;
    sb_push("tim_read_dout2", 8'hA5); chk(DOUT);
    tick(); idle();
    sb_push("irq_after_tim_read", 8'h01); chk(IRQ_N);
    TIM_UF = 1'b1; tick(); TIM_UF = 1'b0;
    sb_push("irq_masked_tflag", 8'h01); chk(IRQ_N);
    flag_read("tflag_sets_unmasked", 8'h80);
    bus(1'b1, 1'b1, 5'h04, 8'h00); tick(); idle();

    // PA7 rising-edge interrupt
    bus(1'b1, 1'b0, 5'h07, 8'h00);
    #1;
    sb_push("we_on_ctl_write", 8'h00); chk(TIM_WE);
    tick(); idle();
    PA7 = 1'b1;
    n = 0;
    while (IRQ_N !== 1'b0 && n < SYNC_STAGES + 2) begin
      tick();
      n++;
    end
    sb_push("pa7_rise_irq", 8'h00); chk(IRQ_N);
    flag_read("flag_read_pflag", 8'h40);
    sb_push("irq_after_pflag_clr", 8'h01); chk(IRQ_N);
    PA7 = 1'b0;
    repeat (6) tick();
    sb_push("irq_fall_ignored", 8'h01); chk(IRQ_N);
    flag_read("fall_sets_nothing", 8'h00);

    // Polarity change alone, then enable with a pending flag
    bus(1'b1, 1'b0, 5'h04, 8'h00); tick(); idle();
    repeat (4) tick();
    flag_read("ppol_change_noedge", 8'h00);
    PA7 = 1'b1; repeat (5) tick();
    PA7 = 1'b0; repeat (5) tick();
    sb_push("irq_pen0_pending", 8'h01); chk(IRQ_N);
    bus(1'b1, 1'b0, 5'h06, 8'h00); tick(); idle();
    sb_push("irq_pen_enable", 8'h00); chk(IRQ_N);
    flag_read("flag_read_fall", 8'h40);

    // Edge detected in the same cycle as a flag read
    PA7 = 1'b1; repeat (5) tick();
    PA7 = 1'b0; tick(); tick();
    bus(1'b1, 1'b1, 5'h05, 8'h00);
    #1;
    sb_push("dout_before_set", 8'h00); chk(DOUT);
    tick(); idle();
    sb_push("irq_edge_read_setwins", 8'h00); chk(IRQ_N);
    flag_read("pflag_kept", 8'h40);

    // Underflow coinciding with a timer write
    bus(1'b1, 1'b0, 5'h1C, 8'h00); tick(); idle();
    TIM_UF = 1'b1; tick(); TIM_UF = 1'b0;
    sb_push("irq_uf_ten", 8'h00); chk(IRQ_N);
    bus(1'b1, 1'b0, 5'h1C, 8'h00); TIM_UF = 1'b1; tick(); TIM_UF = 1'b0; idle();
    sb_push("irq_uf_write_clearwins", 8'h01); chk(IRQ_N);
    flag_read("tflag_write_clear", 8'h00);

    // Reset mid-operation with both flags set and PA7 high
    bus(1'b1, 1'b0, 5'h07, 8'h00); tick(); idle();
    PA7 = 1'b1; repeat (5) tick();
    TIM_UF = 1'b1; tick(); TIM_UF = 1'b0;
    sb_push("irq_both_flags", 8'h00); chk(IRQ_N);
    RES = 1'b1; TIM_UF = 1'b1; tick();
    sb_push("irq_reset_mid", 8'h01); chk(IRQ_N);
    tick(); RES = 1'b0; TIM_UF = 1'b0;
    repeat (8) tick();
    flag_read("no_spurious_after_reset", 8'h00);
    sb_push("irq_after_reset", 8'h01); chk(IRQ_N);

    // Deselected accesses have no side effects
    TIM_UF = 1'b1; tick(); TIM_UF = 1'b0;
    bus(1'b0, 1'b0, 5'h1F, 8'hFF);
    #1;
    sb_push("cs0_tim_we", 8'h00); chk(TIM_WE);
    sb_push("cs0_dout", 8'h00);   chk(DOUT);
    tick();
    bus(1'b0, 1'b1, 5'h04, 8'h00);
    #1;
    sb_push("cs0_read_dout", 8'h00); chk(DOUT);
    tick(); idle();
    flag_read("cs0_no_state_change", 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 The block SHALL have one parameter: SYNC_STAGES, default 2, number of PA7 synchronizer flops (legal 2..3).
REQ-002 The block SHALL have these ports:
  CLK  in  1  single clock; all state updates on its rising edge
  RES  in  1  reset, synchronous, active-high
  CS  in  1  chip select for this register bank
  RW  in  1  1 = read, 0 = write
  A  in  5  register address
  DIN  in  8  write data
  PA7  in  1  asynchronous edge-detect input
  TIM_UF  in  1  one-cycle pulse from the interval timer when its count wraps past 0x00
  TIM_OUT  in  8  current interval-timer value
  TIM_WE  out  1  timer load strobe
  TIM_MODE  out  2  timer prescale select (00 = 1T, 01 = 8T, 10 = 64T, 11 = 1024T)
  TIM_IN  out  8  timer load value
  DOUT  out  8  read data
  IRQ_N  out  1  interrupt request, active-low

Function
REQ-003 An access is active when CS=1; with CS=0 the block SHALL have no side effects and drive DOUT=0x00.
REQ-004 Timer write decode: CS=1, RW=0, A[4]=1, A[2]=1 -> TIM_WE=1 in the same cycle, with TIM_MODE=A[1:0] and TIM_IN=DIN (combinational, zero latency).
REQ-005 Every timer write SHALL load timer-IRQ-enable TEN <= A[3] and clear the timer flag TFLAG at the same edge.
REQ-006 Edge-control write: CS=1, RW=0, A[4]=0, A[2]=1 -> PEN <= A[1] (PA7 IRQ enable) and PPOL <= A[0] (0 = falling edge, 1 = rising edge).
REQ-007 Timer read: CS=1, RW=1, A[2]=1, A[0]=0 -> DOUT=TIM_OUT; TEN <= A[3]; TFLAG cleared at the edge ending the access.
REQ-008 Flag read: CS=1, RW=1, A[2]=1, A[0]=1 -> DOUT={TFLAG, PFLAG, 6'b0}; PFLAG cleared at the edge ending the access; TFLAG unchanged.
REQ-009 Any other address with CS=1 SHALL return DOUT=0x00 and have no side effects.
REQ-010 PA7 SHALL pass through SYNC_STAGES flops, followed by one history flop; an edge is detected when the two last samples differ in the direction selected by PPOL.
REQ-011 Edge latency: a PA7 transition held stable SHALL set PFLAG no later than SYNC_STAGES+2 cycles after it occurs.
REQ-012 TFLAG SHALL be set on the edge following any cycle with TIM_UF=1.
REQ-013 Simultaneous events:
  - TIM_UF with timer read: set wins.
  - TIM_UF with timer write: clear wins.
  - Detected edge with flag read: set wins.
REQ-014 A PPOL change SHALL take effect from the next cycle and SHALL NOT itself generate an edge.
REQ-015 IRQ_N SHALL equal ~((TFLAG & TEN) | (PFLAG & PEN)) from registered state (no combinational path from bus inputs).
REQ-016 Flags SHALL set regardless of their enables; an enable write of 1 with a pending flag SHALL assert IRQ_N the next cycle.

Reset
REQ-017 On RES=1 at a rising edge, the block SHALL clear TFLAG, PFLAG, TEN, PEN, PPOL and all synchronizer/history flops; IRQ_N=1 from the next cycle.
REQ-018 While RES=1, TIM_WE SHALL be forced to 0 regardless of bus inputs.
REQ-019 While RES=1, a TIM_UF or PA7 edge SHALL NOT set any flag.
REQ-020 After RES deasserts, edge detection SHALL NOT fire until the synchronizer is refilled; no false edge from reset-zero history.

Structure
REQ-021 Shared package mm6532_pkg SHALL hold:
  - the timer mode encodings (C_TIM_0001T..C_TIM_1024T);
  - address-bit position constants (A_TIMER=2, A_WSEL=4, A_IEN=3, A_FLAGSEL=0);
  - the flag bit positions (TFLAG=7, PFLAG=6).
REQ-022 The PA7 synchronizer and polarity-selectable edge detector SHALL be one sub-module, edge_det, parameterised by SYNC_STAGES.
REQ-023 The block SHALL NOT instantiate the interval timer; it connects to it only through the TIM_* ports.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
  - Write A=0x1D, DIN=0x05: TIM_WE=1 that cycle, TIM_MODE=01, TIM_IN=0x05, TEN=1. Then pulse TIM_UF: IRQ_N=0 next cycle, flag read DOUT=0x80.
  - Timer read A=0x04 after a flag is set: DOUT=TIM_OUT, IRQ_N returns to 1 next cycle. TIM_UF in the same read cycle: TFLAG stays 1.
  - Write A=0x07 (PEN=1, rising edge): PA7 0->1 gives IRQ_N=0 within SYNC_STAGES+2 cycles. Flag read A=0x05 returns 0x40, then PFLAG=0. A 1->0 transition sets nothing.
  - TIM_UF and a timer write in the same cycle: TFLAG=0, IRQ_N=1.
  - RES asserted mid-operation with both flags set and PA7=1: all flags clear, IRQ_N=1, no spurious PFLAG after release.
  - CS=0 with RW=0, A=0x1F: TIM_WE=0, DOUT=0x00, no state change.
